debounce_event_arbiter: RTL and testbench

//   Debounces N raw button/switch inputs using one shared millisecond prescaler.

---
 rtl/debounce_pkg.sv | 17 +
 rtl/debounce_channel.sv | 116 +++++++++++
 rtl/debounce_event_arbiter.sv | 135 +++++++++++++
 tb/tb_debounce_event_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared event encodings and width helpers for the debounce/event arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package debounce_pkg;

    localparam int EVT_W = 2;

    localparam logic [EVT_W-1:0] EVT_FALL = 2'b00;
    localparam logic [EVT_W-1:0] EVT_RISE = 2'b01;
    localparam logic [EVT_W-1:0] EVT_LONG = 2'b10;

    // Channel index width; a single channel still needs one bit.
    function automatic int chan_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: 2-FF sync, tick-based debounce counter, pending edge flag, sticky overflow.
// Latency: 2 sync cycles + DEBOUNCE_TIME-1..DEBOUNCE_TIME ticks from raw change to accepted level.
// Backpressure: pending flag waits for the arbiter clear; a new acceptance overwrites it and flags overflow.
// Optional LONG_PRESS_EN adds a saturating hold counter raising lpend once per press.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_TIME   = 5,
    parameter int LONG_PRESS_TIME = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic tick,
    input  logic clr_pend,
    input  logic clr_lpend,
    input  logic clear_overflow,
    output logic stable,
    output logic pend,
    output logic plevel,
    output logic lpend,
    output logic overflow
);

    localparam int CNT_W = $clog2(DEBOUNCE_TIME + 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    // The level is accepted on the tick that completes DEBOUNCE_TIME differing ticks.
    assign accept = tick && (s2 != stable) && (cnt == CNT_W'(DEBOUNCE_TIME - 1));

    // Two-stage synchronizer; reset preloads the current input so no edge is seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= raw;
            s2 <= raw;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Debounce counter: any return to the stable level restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= raw;
            cnt    <= '0;
        end else if (s2 == stable) begin
            cnt <= '0;
        end else if (tick) begin
            if (accept) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Pending edge flag; a new acceptance wins over the arbiter's clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend   <= 1'b0;
            plevel <= 1'b0;
        end else if (accept) begin
            pend   <= 1'b1;
            plevel <= s2;
        end else if (clr_pend) begin
            pend <= 1'b0;
        end
    end

    // Sticky overflow when an untaken edge is overwritten; setting wins over clearing.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (accept && pend && !clr_pend) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

`ifdef LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_PRESS_TIME + 1);

    logic [HOLD_W-1:0] hold;

    // Hold counter saturates at LONG_PRESS_TIME so lpend rises only once per press.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold  <= '0;
            lpend <= 1'b0;
        end else begin
            if (!stable) begin
                hold <= '0;
            end else if (tick && (hold != HOLD_W'(LONG_PRESS_TIME))) begin
                hold <= hold + 1'b1;
            end
            if (stable && tick && (hold == HOLD_W'(LONG_PRESS_TIME - 1))) begin
                lpend <= 1'b1;
            end else if (clr_lpend) begin
                lpend <= 1'b0;
            end
        end
    end
`else
    logic unused_long;
    assign unused_long = clr_lpend | (LONG_PRESS_TIME == 0);
    assign lpend       = 1'b0;
`endif

endmodule

// File: rtl/debounce_event_arbiter.sv
// N debounced inputs sharing one 1 ms prescaler, edge events arbitrated round-robin onto one port.
// Latency: one cycle from a pending flag to event_valid when the output register is free.
// Backpressure: valid/ready; the event is held while valid && !ready, flags keep pending.
// Build with LONG_PRESS_EN to add long-press events (type 10).
module debounce_event_arbiter
    import debounce_pkg::*;
#(
    parameter int N_CHAN          = 4,
    parameter int CLOCK_FREQUENCY = 50,
    parameter int DEBOUNCE_TIME   = 5,
    parameter int LONG_PRESS_TIME = 1000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [N_CHAN-1:0]               raw_in,
    output logic [N_CHAN-1:0]               stable_state,
    output logic                            event_valid,
    input  logic                            event_ready,
    output logic [chan_width(N_CHAN)-1:0]   event_chan,
    output logic [EVT_W-1:0]                event_type,
    output logic [N_CHAN-1:0]               overflow,
    input  logic [N_CHAN-1:0]               clear_overflow
);

    localparam int CHAN_W = chan_width(N_CHAN);
    localparam int TICK   = CLOCK_FREQUENCY * 1000;
    localparam int PRE_W  = $clog2(TICK);

    logic [PRE_W-1:0]  pre;
    logic              tick;
    logic [N_CHAN-1:0] pend;
    logic [N_CHAN-1:0] plevel;
    logic [N_CHAN-1:0] lpend;
    logic [N_CHAN-1:0] clr_pend;
    logic [N_CHAN-1:0] clr_lpend;
    logic [CHAN_W-1:0] last_grant;
    logic [CHAN_W-1:0] grant;
    logic [CHAN_W-1:0] idx;
    logic [EVT_W-1:0]  grant_type;
    logic              found;
    logic              grant_long;
    logic              load;
    int                pos;

    assign tick = (pre == PRE_W'(TICK - 1));

    // Shared millisecond prescaler, one-cycle tick at the top of its range.
    always_ff @(posedge clk) begin
        if (reset || tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    for (genvar c = 0; c < N_CHAN; c++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_TIME   (DEBOUNCE_TIME),
            .LONG_PRESS_TIME (LONG_PRESS_TIME)
        ) u_chan (
            .clk            (clk),
            .reset          (reset),
            .raw            (raw_in[c]),
            .tick           (tick),
            .clr_pend       (clr_pend[c]),
            .clr_lpend      (clr_lpend[c]),
            .clear_overflow (clear_overflow[c]),
            .stable         (stable_state[c]),
            .pend           (pend[c]),
            .plevel         (plevel[c]),
            .lpend          (lpend[c]),
            .overflow       (overflow[c])
        );
    end

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        found      = 1'b0;
        grant      = '0;
        grant_long = 1'b0;
        idx        = '0;
        pos        = 0;
        for (int i = 0; i < N_CHAN; i++) begin
            pos = int'(last_grant) + 1 + i;
            if (pos >= N_CHAN) begin
                pos = pos - N_CHAN;
            end
            idx = CHAN_W'(pos);
            if (!found && (pend[idx] || lpend[idx])) begin
                found      = 1'b1;
                grant      = idx;
                grant_long = !pend[idx];
            end
        end
    end

    // Edge events take priority over long-press within a channel.
    assign grant_type = grant_long ? EVT_LONG : (plevel[grant] ? EVT_RISE : EVT_FALL);
    assign load       = !event_valid || event_ready;

    // Clear the granted flag in the same cycle the output register captures it.
    always_comb begin
        clr_pend  = '0;
        clr_lpend = '0;
        for (int c = 0; c < N_CHAN; c++) begin
            if (load && found && (grant == CHAN_W'(c))) begin
                if (grant_long) begin
                    clr_lpend[c] = 1'b1;
                end else begin
                    clr_pend[c] = 1'b1;
                end
            end
        end
    end

    // Output register and arbiter pointer; both frozen during a stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            event_valid <= 1'b0;
            event_chan  <= '0;
            event_type  <= EVT_FALL;
            last_grant  <= CHAN_W'(N_CHAN - 1);
        end else if (load) begin
            if (found) begin
                event_valid <= 1'b1;
                event_chan  <= grant;
                event_type  <= grant_type;
                last_grant  <= grant;
            end else begin
                event_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_debounce_event_arbiter.sv
// Bench for debounce_event_arbiter: directed scenarios plus random bouncing inputs,
// checked every cycle against a behavioural model of debounce and round-robin rules.
// Build with LONG_PRESS_EN to expect long-press events.
module tb_debounce_event_arbiter;

    localparam int N    = 4;
    localparam int CF   = 1;
    localparam int TICK = CF * 1000;
    localparam int DT   = 3;
    localparam int LPT  = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] raw_in;
    logic [3:0] stable_state;
    logic       event_valid;
    logic       event_ready;
    logic [1:0] event_chan;
    logic [1:0] event_type;
    logic [3:0] overflow;
    logic [3:0] clear_overflow;

    debounce_event_arbiter #(
        .N_CHAN          (N),
        .CLOCK_FREQUENCY (CF),
        .DEBOUNCE_TIME   (DT),
        .LONG_PRESS_TIME (LPT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .raw_in         (raw_in),
        .stable_state   (stable_state),
        .event_valid    (event_valid),
        .event_ready    (event_ready),
        .event_chan     (event_chan),
        .event_type     (event_type),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_no  = 0;

    // Reference model state (plain integers)
    int m_s1[N], m_s2[N], m_stab[N], m_run[N], m_pend[N], m_plev[N];
    int m_lp[N], m_hold[N], m_ovf[N];
    int m_cyc, m_valid, m_chan, m_type, m_last;

    // Handshake log of the DUT
    int log_chan[$];
    int log_type[$];
    int log_cyc[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge of the behavioural model, using the inputs present at the edge.
    task automatic model_edge();
        int tick, take, take_long, c, newly_long, accepted, old_stab;
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                m_s1[k] = raw_in[k]; m_s2[k] = raw_in[k]; m_stab[k] = raw_in[k];
                m_run[k] = 0; m_pend[k] = 0; m_plev[k] = 0;
                m_lp[k] = 0; m_hold[k] = 0; m_ovf[k] = 0;
            end
            m_cyc = 0; m_valid = 0; m_chan = 0; m_type = 0; m_last = N - 1;
            return;
        end
        tick  = (m_cyc == TICK - 1);
        m_cyc = (m_cyc + 1) % TICK;
        take = -1; take_long = 0;
        if (!m_valid || event_ready) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (take < 0 && (m_pend[c] != 0 || m_lp[c] != 0)) take = c;
            end
            if (take >= 0) begin
                m_valid = 1; m_chan = take; m_last = take;
                if (m_pend[take] != 0) m_type = (m_plev[take] != 0) ? 1 : 0;
                else begin m_type = 2; take_long = 1; end
            end else begin
                m_valid = 0;
            end
        end
        for (int k = 0; k < N; k++) begin
            old_stab = m_stab[k];
            newly_long = 0;
`ifdef LONG_PRESS_EN
            if (old_stab == 0) m_hold[k] = 0;
            else if (tick != 0 && m_hold[k] < LPT) begin
                m_hold[k]++;
                if (m_hold[k] == LPT) newly_long = 1;
            end
`endif
            accepted = 0;
            if (m_s2[k] != old_stab) begin
                if (tick != 0) begin
                    m_run[k]++;
                    if (m_run[k] == DT) begin
                        accepted = 1; m_run[k] = 0; m_stab[k] = m_s2[k];
                    end
                end
            end else begin
                m_run[k] = 0;
            end
            if (accepted != 0) begin
                if (m_pend[k] != 0 && !(take == k && take_long == 0)) m_ovf[k] = 1;
                else if (clear_overflow[k]) m_ovf[k] = 0;
                m_pend[k] = 1; m_plev[k] = m_stab[k];
            end else begin
                if (take == k && take_long == 0) m_pend[k] = 0;
                if (clear_overflow[k]) m_ovf[k] = 0;
            end
            if (newly_long != 0) m_lp[k] = 1;
            else if (take == k && take_long != 0) m_lp[k] = 0;
            m_s2[k] = m_s1[k];
            m_s1[k] = raw_in[k];
        end
    endtask

    task automatic step();
        logic [3:0] es, eo;
        logic [1:0] ec, et;
        if (event_valid === 1'b1 && event_ready === 1'b1) begin
            log_chan.push_back(int'(event_chan));
            log_type.push_back(int'(event_type));
            log_cyc.push_back(cyc_no);
        end
        @(posedge clk);
        model_edge();
        #1;
        cyc_no++;
        for (int k = 0; k < N; k++) begin
            es[k] = (m_stab[k] != 0);
            eo[k] = (m_ovf[k] != 0);
        end
        ec = 2'(m_chan);
        et = 2'(m_type);
        check_eq("outputs", {19'b0, stable_state, event_valid, event_chan, event_type, overflow},
                 {19'b0, es, m_valid != 0, ec, et, eo});
        if (n_fail >= 25) begin
            $display("FAIL abort: too many errors at cycle %0d, stopping early", cyc_no);
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_log();
        log_chan.delete(); log_type.delete(); log_cyc.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run(2);
        reset = 1'b0;
    endtask

    initial begin
        int t0, lat;
        reset = 1'b1; raw_in = 4'b0000; event_ready = 1'b1; clear_overflow = 4'b0000;
        run(3);
        check_eq("reset_valid", {31'b0, event_valid}, 32'd0);
        check_eq("reset_overflow", {28'b0, overflow}, 32'd0);
        check_eq("reset_stable", {28'b0, stable_state}, 32'd0);
        reset = 1'b0;

        // 1: single rise on channel 2
        clear_log();
        raw_in[2] = 1'b1;
        t0 = cyc_no;
        run(3200);
        check_eq("t1_count", log_chan.size(), 1);
        if (log_chan.size() == 1) begin
            check_eq("t1_chan", log_chan[0], 2);
            check_eq("t1_type", log_type[0], 1);
            lat = log_cyc[0] - t0 - 1;
            check_eq("t1_latency_in_window", {31'b0, lat >= 2000 && lat <= 3002}, 1);
        end
        check_eq("t1_stable2", {31'b0, stable_state[2]}, 1);

        // 2: 1.5 ms pulse is rejected as a bounce
        clear_log();
        raw_in[1] = 1'b1;
        run(1500);
        raw_in[1] = 1'b0;
        run(3500);
        check_eq("t2_no_event", log_chan.size(), 0);
        check_eq("t2_stable1", {31'b0, stable_state[1]}, 0);

        // 3: simultaneous acceptance on channels 0 and 3, pointer from reset
        do_reset();
        clear_log();
        raw_in[0] = 1'b1; raw_in[3] = 1'b1;
        run(3200);
        check_eq("t3_rise_count", log_chan.size(), 2);
        if (log_chan.size() == 2) begin
            check_eq("t3_first", log_chan[0], 0);
            check_eq("t3_second", log_chan[1], 3);
            check_eq("t3_back_to_back", log_cyc[1] - log_cyc[0], 1);
        end
        clear_log();
        raw_in[0] = 1'b0; raw_in[3] = 1'b0;
        run(3200);
        check_eq("t3_fall_count", log_chan.size(), 2);
        if (log_chan.size() == 2) begin
            check_eq("t3_fall_first", log_chan[0], 0);
            check_eq("t3_fall_second", log_chan[1], 3);
            check_eq("t3_fall_type", log_type[0], 0);
        end

        // 4: stalled consumer, channel 1 overwritten
        event_ready = 1'b0;
        raw_in[2] = 1'b0;
        run(3200);
        raw_in[1] = 1'b1;
        run(3200);
        raw_in[1] = 1'b0;
        run(3200);
        check_eq("t4_overflow1", {31'b0, overflow[1]}, 1);
        check_eq("t4_stall_valid", {31'b0, event_valid}, 1);
        check_eq("t4_stall_chan", {30'b0, event_chan}, 2);
        clear_log();
        event_ready = 1'b1;
        run(6);
        check_eq("t4_drain_count", log_chan.size(), 2);
        if (log_chan.size() == 2) begin
            check_eq("t4_drain_chan1", log_chan[1], 1);
            check_eq("t4_drain_type1", log_type[1], 0);
        end
        clear_overflow = 4'b0010;
        step();
        clear_overflow = 4'b0000;
        check_eq("t4_overflow_cleared", {31'b0, overflow[1]}, 0);

        // 5: reset in the middle of a count
        raw_in = 4'b0101;
        run(1500);
        reset = 1'b1;
        run(2);
        check_eq("t5_stable", {28'b0, stable_state}, 32'h5);
        check_eq("t5_valid", {31'b0, event_valid}, 0);
        reset = 1'b0;
        clear_log();
        run(4000);
        check_eq("t5_no_event", log_chan.size(), 0);

        // 6: long hold on channel 0
        raw_in = 4'b0000;
        run(3200);
        clear_log();
        raw_in[0] = 1'b1;
        run(9000);
`ifdef LONG_PRESS_EN
        check_eq("t6_count", log_chan.size(), 2);
        if (log_chan.size() == 2) begin
            check_eq("t6_long_type", log_type[1], 2);
            check_eq("t6_long_chan", log_chan[1], 0);
        end
`else
        check_eq("t6_count", log_chan.size(), 1);
`endif
        if (log_chan.size() >= 1) check_eq("t6_rise_type", log_type[0], 1);

        // Random bouncing inputs, random ready and overflow clears
        for (int seg = 0; seg < 15; seg++) begin
            int dur;
            raw_in = raw_in ^ 4'($urandom_range(1, 15));
            dur = $urandom_range(200, 3000);
            for (int i = 0; i < dur; i++) begin
                event_ready    = ($urandom_range(0, 9) < 7);
                clear_overflow = ($urandom_range(0, 49) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
                step();
            end
        end
        event_ready = 1'b1;
        clear_overflow = 4'b0000;
        run(50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
